// File: rtl/proc_pkg.sv
// Shared constants for the processor control unit: opcodes, T-state encoding, IR layout.
// Optional mvnz opcode is enabled in proc_ctrl by defining PROC_CTRL_MVNZ_EN.
package proc_pkg;

    localparam int IW_DEFAULT   = 9;
    localparam int NREG_DEFAULT = 8;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_MVNZ = 3'b100;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

    // III_XXX_YYY instruction word
    typedef struct packed {
        logic [2:0] op;
        logic [2:0] rx;
        logic [2:0] ry;
    } ir_t;

endpackage

// File: rtl/dec3to8.sv
// Purpose: 3-to-8 one-hot decoder with enable; all-zero output when disabled.
// Latency: combinational, zero cycles.
// Backpressure: none; pure decode.
module dec3to8 (
    input  logic [2:0] w,
    input  logic       en,
    output logic [7:0] y
);

    always_comb begin
        y = '0;
        if (en) begin
            y[w] = 1'b1;
        end
    end

endmodule

// File: rtl/proc_ctrl.sv
// Purpose: processor control unit; holds IR and sequences T0..T3, driving register enables and bus selects.
// Latency: mv/mvi/nop done 2 cycles after T0 (inclusive), add/sub 4; Run sampled only in T0.
// Backpressure: none; Run is ignored while an instruction is in flight. Optional mvnz: PROC_CTRL_MVNZ_EN.
module proc_ctrl
    import proc_pkg::*;
#(
    parameter int IW   = IW_DEFAULT,
    parameter int NREG = NREG_DEFAULT
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic [IW-1:0]   DIN,
    input  logic            Run,
    input  logic            GNZ,
    output logic            IRin,
    output logic [NREG-1:0] Rin,
    output logic [NREG-1:0] Rout,
    output logic            Ain,
    output logic            Gin,
    output logic            Gout,
    output logic            DINout,
    output logic            AddSub,
    output logic            Done
);

    state_t state, next_state;
    ir_t    ir;

    logic       rin_x, rout_x, rout_y;
    logic [7:0] x_oh, y_oh;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= T0;
            ir    <= '0;
        end else begin
            state <= next_state;
            if (IRin) begin
                ir <= DIN;
            end
        end
    end

    // Everything is held low during reset so no datapath register can be written.
    always_comb begin
        next_state = state;
        IRin       = 1'b0;
        rin_x      = 1'b0;
        rout_x     = 1'b0;
        rout_y     = 1'b0;
        Ain        = 1'b0;
        Gin        = 1'b0;
        Gout       = 1'b0;
        DINout     = 1'b0;
        AddSub     = 1'b0;
        Done       = 1'b0;
        if (Reset) begin
            next_state = T0;
        end else begin
            case (state)
                T0: begin
                    IRin       = Run;
                    next_state = Run ? T1 : T0;
                end
                T1: begin
                    next_state = T0;
                    case (ir.op)
                        OP_MV: begin
                            rout_y = 1'b1;
                            rin_x  = 1'b1;
                            Done   = 1'b1;
                        end
                        OP_MVI: begin
                            DINout = 1'b1;
                            rin_x  = 1'b1;
                            Done   = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            rout_x     = 1'b1;
                            Ain        = 1'b1;
                            next_state = T2;
                        end
`ifdef PROC_CTRL_MVNZ_EN
                        OP_MVNZ: begin
                            rout_y = 1'b1;
                            rin_x  = GNZ;
                            Done   = 1'b1;
                        end
`endif
                        default: begin
                            Done = 1'b1;
                        end
                    endcase
                end
                T2: begin
                    rout_y     = 1'b1;
                    Gin        = 1'b1;
                    AddSub     = (ir.op == OP_SUB);
                    next_state = T3;
                end
                T3: begin
                    Gout       = 1'b1;
                    rin_x      = 1'b1;
                    Done       = 1'b1;
                    next_state = T0;
                end
                default: begin
                    next_state = T0;
                end
            endcase
        end
    end

`ifndef PROC_CTRL_MVNZ_EN
    logic unused_gnz;
    assign unused_gnz = GNZ;
`endif

    dec3to8 u_dec_x (
        .w  (ir.rx),
        .en (rin_x | rout_x),
        .y  (x_oh)
    );

    dec3to8 u_dec_y (
        .w  (ir.ry),
        .en (rout_y),
        .y  (y_oh)
    );

    assign Rin  = rin_x  ? x_oh : '0;
    assign Rout = (rout_x ? x_oh : '0) | y_oh;

endmodule
